// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
//   Shared pipeline definitions: memory opcodes seen in IR[31:26], the
//   arbiter FSM state encoding and the requester identifier used for grants.
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    // Opcodes (IR[31:26]) that make the MEM stage talk to the data RAM
    localparam logic [5:0] OP_LW_CODE = 6'b001000;
    localparam logic [5:0] OP_SW_CODE = 6'b001001;

    // Arbiter FSM: IDLE -> ACC (RAM strobe) -> RSP (read data returns)
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_RSP  = 2'd2
    } arb_state_t;

    // Requester identity; also the round-robin history bit
    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } grant_t;

    // The requester that is not g
    function automatic grant_t other_grant(input grant_t g);
        return (g == GNT_MEM) ? GNT_IF : GNT_MEM;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one external single-port RAM between the instruction fetch (IF)
//   and the MEM pipeline stage. Each access takes two FSM cycles: ACC drives
//   the RAM strobe from latched request fields, RSP captures the returned
//   word. Contention is resolved round-robin.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   EX_MEM_IR           : MEM-stage instruction; LW/SW opcodes request the RAM
//   EX_MEM_ALU_output   : MEM-stage word address (low ADDR_W bits)
//   EX_MEM_B            : store data
//   MEM_WB_LMD          : registered load data
//   mem_stall           : MEM request outstanding and not completing this cycle
//   if_req / if_addr    : fetch request (held until if_valid) and word address
//   if_rdata / if_valid : registered fetch data and one-cycle completion pulse
//   ram_*               : single-port RAM, read data valid the cycle after ram_en
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int         ADDR_W = 10,
    parameter logic [5:0] OP_LW  = OP_LW_CODE,
    parameter logic [5:0] OP_SW  = OP_SW_CODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       EX_MEM_IR,
    input  logic [31:0]       EX_MEM_ALU_output,
    input  logic [31:0]       EX_MEM_B,
    output logic [31:0]       MEM_WB_LMD,
    output logic              mem_stall,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_valid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    arb_state_t        state, state_nxt;
    grant_t            last_grant, grant_nxt;
    logic              acc_start;
    logic              mem_req;
    logic              is_sw;
    logic              mem_done;
    logic              in_rsp;

    // Fields frozen for the duration of one access
    logic [ADDR_W-1:0] acc_addr;
    logic              acc_we;
    logic [31:0]       acc_wdata;

    // Only the opcode and the low address bits matter to this block
    logic              unused_bits;
    assign unused_bits = ^{EX_MEM_IR[25:0], EX_MEM_ALU_output[31:ADDR_W],
                           if_addr[31:ADDR_W]};

    assign is_sw   = (EX_MEM_IR[31:26] == OP_SW);
    assign mem_req = (EX_MEM_IR[31:26] == OP_LW) || is_sw;
    assign in_rsp  = (state == ST_RSP);

    // last_grant doubles as the identity of the access in flight
    assign mem_done = in_rsp && (last_grant == GNT_MEM) && !rst;
    assign if_valid = in_rsp && (last_grant == GNT_IF)  && !rst;

    assign mem_stall = mem_req && !(in_rsp && (last_grant == GNT_MEM));

    // rst gates the strobe so an access caught in ACC never lands in the RAM
    assign ram_en    = (state == ST_ACC) && !rst;
    assign ram_we    = (state == ST_ACC) && acc_we && !rst;
    assign ram_addr  = acc_addr;
    assign ram_wdata = acc_wdata;

    always_comb begin
        state_nxt = state;
        grant_nxt = last_grant;
        acc_start = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req || if_req) begin
                    state_nxt = ST_ACC;
                    acc_start = 1'b1;
                    if (mem_req && if_req)
                        grant_nxt = other_grant(last_grant);
                    else
                        grant_nxt = mem_req ? GNT_MEM : GNT_IF;
                end
            end
            ST_ACC: begin
                state_nxt = ST_RSP;
            end
            ST_RSP: begin
                // The completing requester still shows its old request this
                // cycle, so only the other side may start the next access.
                if ((last_grant == GNT_MEM) ? if_req : mem_req) begin
                    state_nxt = ST_ACC;
                    acc_start = 1'b1;
                    grant_nxt = other_grant(last_grant);
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= GNT_IF;
            acc_addr   <= '0;
            acc_we     <= 1'b0;
            acc_wdata  <= '0;
            MEM_WB_LMD <= '0;
            if_rdata   <= '0;
        end else begin
            state <= state_nxt;
            if (acc_start) begin
                last_grant <= grant_nxt;
                if (grant_nxt == GNT_MEM) begin
                    acc_addr  <= EX_MEM_ALU_output[ADDR_W-1:0];
                    acc_we    <= is_sw;
                    acc_wdata <= EX_MEM_B;
                end else begin
                    acc_addr  <= if_addr[ADDR_W-1:0];
                    acc_we    <= 1'b0;
                    acc_wdata <= '0;
                end
            end
            // RSP: RAM output holds the word read in ACC
            if (mem_done && !acc_we)
                MEM_WB_LMD <= ram_rdata;
            if (if_valid)
                if_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter with a behavioural single-port RAM.
//   Expected RAM accesses are queued as stimulus is applied and popped by a
//   monitor whenever the arbiter strobes the RAM.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    localparam logic [31:0] IR_LW  = 32'h2085_0004;
    localparam logic [31:0] IR_SW  = 32'h2485_0008;
    localparam logic [31:0] IR_NOP = 32'h0000_0000;
    localparam logic [31:0] IR_OP1 = 32'h0400_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] EX_MEM_IR = IR_NOP;
    logic [31:0] EX_MEM_ALU_output = '0;
    logic [31:0] EX_MEM_B = '0;
    logic [31:0] MEM_WB_LMD;
    logic        mem_stall;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        ram_en;
    logic        ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    acc_t exp_q[$];
    acc_t mon_e;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .EX_MEM_IR        (EX_MEM_IR),
        .EX_MEM_ALU_output(EX_MEM_ALU_output),
        .EX_MEM_B         (EX_MEM_B),
        .MEM_WB_LMD       (MEM_WB_LMD),
        .mem_stall        (mem_stall),
        .if_req           (if_req),
        .if_addr          (if_addr),
        .if_rdata         (if_rdata),
        .if_valid         (if_valid),
        .ram_en           (ram_en),
        .ram_we           (ram_we),
        .ram_addr         (ram_addr),
        .ram_wdata        (ram_wdata),
        .ram_rdata        (ram_rdata)
    );

    // Unwritten words read back a pattern derived from the address
    function automatic logic [31:0] ram_dflt(input logic [9:0] a);
        return (a == 10'd5) ? 32'h0000_1234 : {16'hA5A5, 6'b0, a};
    endfunction

    logic [31:0] ram_mem [0:1023];
    bit          ram_wr  [0:1023];

    always @(posedge clk) begin
        if (ram_en) begin
            ram_rdata <= ram_wr[ram_addr] ? ram_mem[ram_addr] : ram_dflt(ram_addr);
            if (ram_we) begin
                ram_mem[ram_addr] <= ram_wdata;
                ram_wr[ram_addr]  <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_acc(input logic we, input logic [9:0] a, input logic [31:0] d);
        acc_t e;
        e.we = we; e.addr = a; e.wdata = d;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every RAM strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst && ram_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ram_access", 32'(ram_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_ram_we", 32'(ram_we), 32'(mon_e.we));
                chk("sb_ram_addr", 32'(ram_addr), 32'(mon_e.addr));
                if (mon_e.we)
                    chk("sb_ram_wdata", ram_wdata, mon_e.wdata);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        EX_MEM_IR = IR_NOP;
        if_req = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_lmd", MEM_WB_LMD, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_stall", 32'(mem_stall), 32'd0);
        next_cycle();
        rst = 1'b0;
    endtask

    // Uncontended load from IDLE; result checked once the stall clears
    task automatic do_lw(input logic [9:0] a, input logic [31:0] d, input string tag);
        EX_MEM_IR = IR_LW;
        EX_MEM_ALU_output = 32'(a);
        push_acc(1'b0, a, 32'd0);
        next_cycle();
        next_cycle();
        next_cycle();
        EX_MEM_IR = IR_NOP;
        @(negedge clk);
        chk(tag, MEM_WB_LMD, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Uncontended load: request cycle N
        EX_MEM_IR = IR_LW;
        EX_MEM_ALU_output = 32'd5;
        push_acc(1'b0, 10'd5, 32'd0);
        @(negedge clk);
        chk("lw_stall_n", 32'(mem_stall), 32'd1);
        chk("lw_ram_en_n", 32'(ram_en), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lw_ram_en_n1", 32'(ram_en), 32'd1);
        chk("lw_ram_addr_n1", 32'(ram_addr), 32'd5);
        chk("lw_stall_n1", 32'(mem_stall), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lw_stall_n2", 32'(mem_stall), 32'd0);
        chk("lw_ram_en_n2", 32'(ram_en), 32'd0);
        next_cycle();
        EX_MEM_IR = IR_NOP;
        @(negedge clk);
        chk("lw_lmd", MEM_WB_LMD, 32'h0000_1234);

        // Store
        next_cycle();
        EX_MEM_IR = IR_SW;
        EX_MEM_ALU_output = 32'd3;
        EX_MEM_B = 32'd127;
        push_acc(1'b1, 10'd3, 32'd127);
        @(negedge clk);
        chk("sw_stall_n", 32'(mem_stall), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("sw_ram_we_n1", 32'(ram_we), 32'd1);
        chk("sw_ram_addr_n1", 32'(ram_addr), 32'd3);
        chk("sw_ram_wdata_n1", ram_wdata, 32'd127);
        next_cycle();
        @(negedge clk);
        chk("sw_stall_n2", 32'(mem_stall), 32'd0);
        next_cycle();
        EX_MEM_IR = IR_NOP;
        @(negedge clk);
        chk("sw_lmd_unchanged", MEM_WB_LMD, 32'h0000_1234);
        next_cycle();
        do_lw(10'd3, 32'd127, "sw_readback");

        // Simultaneous MEM and IF right after reset: MEM wins
        next_cycle();
        do_reset();
        EX_MEM_IR = IR_LW;
        EX_MEM_ALU_output = 32'd5;
        if_req = 1'b1;
        if_addr = 32'd7;
        push_acc(1'b0, 10'd5, 32'd0);
        push_acc(1'b0, 10'd7, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("both_ram_addr_n1", 32'(ram_addr), 32'd5);
        next_cycle();
        @(negedge clk);
        chk("both_stall_n2", 32'(mem_stall), 32'd0);
        chk("both_if_valid_n2", 32'(if_valid), 32'd0);
        next_cycle();
        EX_MEM_IR = IR_NOP;
        @(negedge clk);
        chk("both_ram_en_n3", 32'(ram_en), 32'd1);
        chk("both_ram_addr_n3", 32'(ram_addr), 32'd7);
        chk("both_lmd_n3", MEM_WB_LMD, 32'h0000_1234);
        next_cycle();
        @(negedge clk);
        chk("both_if_valid_n4", 32'(if_valid), 32'd1);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        chk("both_if_valid_n5", 32'(if_valid), 32'd0);
        chk("both_if_rdata", if_rdata, 32'hA5A5_0007);

        // Non-memory opcode: nothing happens for 10 cycles
        next_cycle();
        EX_MEM_IR = IR_OP1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("nop_ram_en", 32'(ram_en), 32'd0);
            chk("nop_stall", 32'(mem_stall), 32'd0);
            chk("nop_lmd", MEM_WB_LMD, 32'h0000_1234);
            next_cycle();
        end

        // Continuous contention: MEM, IF, MEM, ... one done every 2 cycles
        EX_MEM_IR = IR_LW;
        EX_MEM_ALU_output = 32'd5;
        if_req = 1'b1;
        if_addr = 32'd7;
        for (int k = 0; k < 3; k++) begin
            push_acc(1'b0, 10'd5, 32'd0);
            push_acc(1'b0, 10'd7, 32'd0);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            chk("rr_mem_stall", 32'(mem_stall), (k % 4 == 2) ? 32'd0 : 32'd1);
            chk("rr_if_valid", 32'(if_valid), (k % 4 == 0 && k > 0) ? 32'd1 : 32'd0);
            next_cycle();
        end
        EX_MEM_IR = IR_NOP;
        if_req = 1'b0;
        @(negedge clk);
        chk("rr_if_valid_tail", 32'(if_valid), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("rr_idle_ram_en", 32'(ram_en), 32'd0);
        chk("rr_if_rdata", if_rdata, 32'hA5A5_0007);

        // Reset during the ACC cycle of a store
        next_cycle();
        EX_MEM_IR = IR_SW;
        EX_MEM_ALU_output = 32'd9;
        EX_MEM_B = 32'h0000_DEAD;
        @(negedge clk);
        chk("abort_stall_n", 32'(mem_stall), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ram_en_acc", 32'(ram_en), 32'd0);
        chk("abort_ram_we_acc", 32'(ram_we), 32'd0);
        next_cycle();
        rst = 1'b0;
        EX_MEM_IR = IR_NOP;
        @(negedge clk);
        chk("abort_ram_en", 32'(ram_en), 32'd0);
        chk("abort_if_valid", 32'(if_valid), 32'd0);
        chk("abort_stall", 32'(mem_stall), 32'd0);
        chk("abort_lmd", MEM_WB_LMD, 32'd0);
        chk("abort_if_rdata", if_rdata, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("abort_idle_ram_en", 32'(ram_en), 32'd0);
        next_cycle();
        do_lw(10'd9, 32'hA5A5_0009, "abort_no_write");

        next_cycle();
        chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
